// File: rtl/drum_pkg.sv
// rtl/drum_pkg.sv - shared constants, FSM encoding and helpers for the note scheduler
//
// Purpose: lane geometry, hit window, game FSM state encoding and the lane-pattern
//          LFSR tap mask, plus a small popcount helper used to sum per-lane events.
// Ports:   none (package).
package drum_pkg;

  localparam int LANES     = 5;
  localparam int Y_W       = 10;
  localparam int HIT_Y_MIN = 384;
  localparam int HIT_Y_MAX = 447;

  // Wide enough to count every press miss plus every escape in one cycle.
  localparam int CNT_W = $clog2(2 * LANES + 1);

  // x^8 + x^6 + x^5 + x^4 (+1): taps on bits 7,5,4,3 of a left-shifting register.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LOST = 2'd2
  } state_t;

  function automatic logic [CNT_W-1:0] popcount(input logic [LANES-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < LANES; i++) n = n + CNT_W'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/lane_lfsr.sv
// rtl/lane_lfsr.sv - 8-bit Fibonacci LFSR that picks the lane for each spawn attempt
//
// Purpose: pseudo-random lane pattern. Reloads the seed on reset or load, advances
//          one step when step is high.
// Ports:   clk   in  1  system clock
//          reset in  1  synchronous, active-high
//          load  in  1  reload SEED (game start)
//          step  in  1  advance one state
//          pick  out 3  low three bits of the current state (raw lane choice)
module lane_lfsr
  import drum_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       step,
  output logic [2:0] pick
);

  logic [7:0] q;
  logic       fb;

  assign fb   = ^(q & LFSR_TAPS);
  assign pick = q[2:0];

  always_ff @(posedge clk) begin
    if (reset || load) begin
      q <= SEED;
    end else if (step) begin
      q <= {q[6:0], fb};
    end
  end

endmodule

// File: rtl/note_scheduler.sv
// rtl/note_scheduler.sv - falling-note game controller: spawns, judges presses, counts misses
//
// Purpose: on rising tick edges in RUN, every SPAWN_EVERY-th edge tries to spawn a note
//          into an LFSR-chosen lane; button rising edges are judged against the hit
//          window; notes falling past the window escape. Misses end the game.
// Config:  SCORE_COUNTER_EN - when defined, score counts hits (saturating);
//          otherwise score is tied to zero.
// Ports:   clk         in  1          system clock
//          reset       in  1          synchronous, active-high
//          enable      in  1          game running (level)
//          tick        in  1          speed clock level; rising edge used
//          boton       in  LANES      drum buttons, active-high
//          lane_active in  LANES      lane holds a falling note
//          lane_y      in  LANES*Y_W  note Y per lane at [i*Y_W +: Y_W]
//          spawn       out LANES      1-cycle: start note in lane
//          clear       out LANES      1-cycle: remove note from lane
//          misses      out 4          miss count (saturates at 15)
//          perdio      out 1          game lost (level)
//          score       out 16         hit count
module note_scheduler
  import drum_pkg::*;
#(
  parameter int         SPAWN_EVERY = 16,
  parameter int         MAX_MISSES  = 8,
  parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 tick,
  input  logic [LANES-1:0]     boton,
  input  logic [LANES-1:0]     lane_active,
  input  logic [LANES*Y_W-1:0] lane_y,
  output logic [LANES-1:0]     spawn,
  output logic [LANES-1:0]     clear,
  output logic [3:0]           misses,
  output logic                 perdio,
  output logic [15:0]          score
);

  localparam int SC_W = $clog2(SPAWN_EVERY);
  localparam logic [Y_W-1:0] Y_MIN = Y_W'(HIT_Y_MIN);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(HIT_Y_MAX);

  state_t state, state_nxt;

  logic             tick_q;
  logic [LANES-1:0] boton_q;
  logic             tick_edge, run, start, wrap;
  logic [LANES-1:0] press, in_win, escape, hit, press_miss, spawn_nxt;
  logic [2:0]       pick, spawn_lane;
  logic [SC_W-1:0]  spawn_cnt;
  logic [4:0]       miss_sum;
  logic [3:0]       misses_nxt;

  assign run       = (state == RUN);
  assign start     = (state == IDLE) && enable;
  assign tick_edge = tick & ~tick_q;
  assign press     = boton & ~boton_q;
  assign wrap      = tick_edge && (spawn_cnt == SC_W'(SPAWN_EVERY - 1));

  lane_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (start),
    .step  (run && tick_edge),
    .pick  (pick)
  );

  // Lane choices beyond the last lane fold back onto the first ones.
  assign spawn_lane = (pick >= 3'(LANES)) ? pick - 3'(LANES) : pick;

  // A lane whose clear is already on the wire is not counted as escaping again
  // while the tube is still dropping its active flag.
  always_comb begin
    in_win = '0;
    escape = '0;
    for (int i = 0; i < LANES; i++) begin
      in_win[i] = lane_active[i] && (lane_y[i*Y_W +: Y_W] >= Y_MIN)
                                 && (lane_y[i*Y_W +: Y_W] <= Y_MAX);
      escape[i] = lane_active[i] && (lane_y[i*Y_W +: Y_W] > Y_MAX) && !clear[i];
    end
  end

  assign hit        = press & in_win;
  assign press_miss = press & ~in_win;
  assign miss_sum   = 5'(misses) + 5'(popcount(press_miss)) + 5'(popcount(escape));
  assign misses_nxt = (miss_sum > 5'd15) ? 4'd15 : miss_sum[3:0];

  always_comb begin
    spawn_nxt = '0;
    if (wrap) spawn_nxt[spawn_lane] = !lane_active[spawn_lane];
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM: next state (losing takes priority over a dropped enable)
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = RUN;
      RUN: begin
        if (misses >= 4'(MAX_MISSES)) state_nxt = LOST;
        else if (!enable)             state_nxt = IDLE;
      end
      LOST:    state_nxt = LOST;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    perdio = (state == LOST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q  <= 1'b0;
      boton_q <= '0;
    end else begin
      tick_q  <= tick;
      boton_q <= boton;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || start) begin
      spawn_cnt <= '0;
      misses    <= '0;
      spawn     <= '0;
      clear     <= '0;
    end else if (run) begin
      spawn  <= spawn_nxt;
      clear  <= hit | escape;
      misses <= misses_nxt;
      if (tick_edge) spawn_cnt <= wrap ? '0 : spawn_cnt + 1'b1;
    end else begin
      spawn <= '0;
      clear <= '0;
    end
  end

`ifdef SCORE_COUNTER_EN
  logic [16:0] score_sum;
  assign score_sum = 17'(score) + 17'(popcount(hit));

  always_ff @(posedge clk) begin
    if (reset || start)  score <= '0;
    else if (run)        score <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
  end
`else
  assign score = 16'd0;
`endif

endmodule
